// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_addsub
// Description : Multi-cycle adder/subtractor. Each operation is accepted in
//               one cycle and then processed CHUNK bits per clock, least
//               significant chunk first, using a single CHUNK-bit adder.
//               Optional signed saturation when ADDSUB_SATURATE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] answer,
    output logic             carry_out,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] c_LAST = CW'(N - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_k;
    logic [WIDTH-1:0] r_a;        // operand A, shifted right one chunk per cycle
    logic [WIDTH-1:0] r_b;        // conditionally inverted operand B, shifted likewise
    logic             r_carry;
    logic             r_a_msb;    // sign bits kept aside for the overflow test
    logic             r_b_msb;

    logic [CHUNK-1:0] w_chunk_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_sum_next; // full sum as it will look after this edge
    logic             w_ovf;
    logic [WIDTH-1:0] w_ans;

    // One CHUNK-wide adder slice working on the current low chunk
    always_comb begin
        {w_cout, w_chunk_sum} = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                              + {{CHUNK{1'b0}}, r_carry};
    end

    // Partial sum storage: completed chunks enter at the top and move down,
    // so after the last chunk the word is already aligned.
    generate
        if (N > 1) begin : g_multi
            logic [WIDTH-CHUNK-1:0] r_sum;

            // Collect finished chunks while busy
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sum <= '0;
                end else if (r_state == c_BUSY) begin
                    r_sum <= w_sum_next[WIDTH-1:CHUNK];
                end
            end

            assign w_sum_next = {w_chunk_sum, r_sum};
        end else begin : g_single
            assign w_sum_next = w_chunk_sum;
        end
    endgenerate

    // Signed overflow: like-signed operands giving a different-signed result
    always_comb begin
        w_ovf = (r_a_msb == r_b_msb) && (w_sum_next[WIDTH-1] != r_a_msb);
    end

    // Final result value, optionally clamped on signed overflow
    always_comb begin
`ifdef ADDSUB_SATURATE_EN
        if (w_ovf) begin
            w_ans = r_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            w_ans = w_sum_next;
        end
`else
        w_ans = w_sum_next;
`endif
    end

    // Control FSM, operand capture, chunk stepping and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_k       <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_carry   <= 1'b0;
            r_a_msb   <= 1'b0;
            r_b_msb   <= 1'b0;
            answer    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_a     <= input1;
                        r_b     <= input2 ^ {WIDTH{sub}};
                        r_carry <= sub;
                        r_a_msb <= input1[WIDTH-1];
                        r_b_msb <= input2[WIDTH-1] ^ sub;
                        r_k     <= '0;
                        r_state <= c_BUSY;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_BUSY: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_carry <= w_cout;
                    r_k     <= r_k + CW'(1);
                    if (r_k == c_LAST) begin
                        answer    <= w_ans;
                        carry_out <= w_cout;
                        overflow  <= w_ovf;
                        r_state   <= c_DONE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == c_BUSY);
    assign done = (r_state == c_DONE);

endmodule
`default_nettype wire
